// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, fetches through a req/ready handshake, absorbs a stalled
// returning word in a one-entry skid buffer and applies branch/jump redirects.
// Optional feature macro: IF_MISALIGN_TRAP_EN (traps misaligned redirects
// in ERR_S and adds the misalign_o port).
module if_fetch_stage #(
  parameter int unsigned              ADDR_W   = 32,
  parameter int unsigned              DATA_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [DATA_W-1:0] ins_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              bubble_o
);

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {RST_S, FETCH_S, SKID_S, ERR_S} state_e;
`else
  typedef enum logic [1:0] {RST_S, FETCH_S, SKID_S} state_e;
`endif

  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [DATA_W-1:0] ins_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [DATA_W-1:0] skid_ins_q;
  logic [ADDR_W-1:0] skid_next_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_pc;
  logic              slot_free;
`ifdef IF_MISALIGN_TRAP_EN
  logic              misalign_q;
  logic              redirect_misaligned;
`endif

  // PC increment (wraps modulo 2^ADDR_W), aligned target, output slot availability
  assign pc_inc      = pc_q + PC_INC;
  assign redirect_pc = redirect_addr_i & ALIGN_MASK;
  assign slot_free   = ~valid_q | ~stall_i;
`ifdef IF_MISALIGN_TRAP_EN
  assign redirect_misaligned = (redirect_addr_i & ~ALIGN_MASK) != '0;
`endif

  // Fetch FSM, PC, output register and skid buffer
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= RST_S;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      ins_q       <= '0;
      next_addr_q <= '0;
      skid_ins_q  <= '0;
      skid_next_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        RST_S: begin
          // A redirect seen during the reset cycle only seeds the PC
          state_q <= FETCH_S;
          if (redirect_i) begin
            pc_q <= redirect_pc;
          end
        end
        default: begin
          if (redirect_i) begin
            // Redirect squashes the presented word, the skid entry and any returning data
            valid_q     <= 1'b0;
            ins_q       <= '0;
            next_addr_q <= '0;
            skid_ins_q  <= '0;
            skid_next_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            if (redirect_misaligned) begin
              pc_q       <= redirect_addr_i;
              state_q    <= ERR_S;
              misalign_q <= 1'b1;
            end else begin
              pc_q       <= redirect_pc;
              state_q    <= FETCH_S;
              misalign_q <= 1'b0;
            end
`else
            pc_q    <= redirect_pc;
            state_q <= FETCH_S;
`endif
          end else begin
            case (state_q)
              FETCH_S: begin
                if (imem_ready_i) begin
                  pc_q <= pc_inc;
                  if (slot_free) begin
                    ins_q       <= imem_rdata_i;
                    next_addr_q <= pc_inc;
                    valid_q     <= 1'b1;
                  end else begin
                    // Downstream is holding a valid word: park the new one
                    skid_ins_q  <= imem_rdata_i;
                    skid_next_q <= pc_inc;
                    state_q     <= SKID_S;
                  end
                end else if (!stall_i) begin
                  valid_q     <= 1'b0;
                  ins_q       <= '0;
                  next_addr_q <= '0;
                end
              end
              SKID_S: begin
                if (!stall_i) begin
                  ins_q       <= skid_ins_q;
                  next_addr_q <= skid_next_q;
                  valid_q     <= 1'b1;
                  state_q     <= FETCH_S;
                end
              end
              default: begin
                // ERR_S holds until reset or an aligned redirect
              end
            endcase
          end
        end
      endcase
    end
  end

  // Request/address decoded from state and PC; everything else straight from registers
  assign imem_req_o  = (state_q == FETCH_S);
  assign imem_addr_o = pc_q;
  assign next_addr_o = next_addr_q;
  assign ins_o       = ins_q;
  assign bubble_o    = ~valid_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage; imem returns 0xDEAD0000 ^ address.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] next_addr;
  logic [31:0] ins;
  logic        bubble;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ready_i    (imem_ready),
    .imem_rdata_i    (imem_rdata),
    .next_addr_o     (next_addr),
    .ins_o           (ins),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_o      (misalign),
`endif
    .bubble_o        (bubble)
  );

  assign imem_rdata = 32'hDEAD_0000 ^ imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0; imem_ready = 1'b1;

    // Reset state
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_bubble", 32'(bubble), 32'd1);
    chk("rst_ins", ins, 32'h0);
    chk("rst_next", next_addr, 32'h0);
    rst_n = 1'b1;

    // Start-up: one request-free cycle, then 0,4,8
    tick();
    chk("fetch0_req", 32'(imem_req), 32'd1);
    chk("fetch0_addr", imem_addr, 32'h0);
    chk("fetch0_bubble", 32'(bubble), 32'd1);
    tick();
    chk("first_addr", imem_addr, 32'h4);
    chk("first_bubble", 32'(bubble), 32'd0);
    chk("first_ins", ins, 32'hDEAD_0000);
    chk("first_next", next_addr, 32'h4);
    tick();
    chk("second_addr", imem_addr, 32'h8);
    chk("second_ins", ins, 32'hDEAD_0004);
    chk("second_next", next_addr, 32'h8);

    // Stall 3 cycles: word at 8 goes to skid, outputs hold
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_next", next_addr, 32'h8);
      chk("stall_ins", ins, 32'hDEAD_0004);
    end
    stall = 1'b0;
    tick();
    chk("skid_ins", ins, 32'hDEAD_0008);
    chk("skid_next", next_addr, 32'hC);
    chk("skid_bubble", 32'(bubble), 32'd0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'hC);
    tick();
    chk("c_ins", ins, 32'hDEAD_000C);
    chk("c_addr", imem_addr, 32'h10);

    // imem not ready for 4 cycles at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_bubble", 32'(bubble), 32'd1);
      chk("wait_ins", ins, 32'h0);
      chk("wait_addr", imem_addr, 32'h10);
    end
    imem_ready = 1'b1;
    tick();
    chk("ready_ins", ins, 32'hDEAD_0010);
    chk("ready_next", next_addr, 32'h14);
    chk("ready_bubble", 32'(bubble), 32'd0);

    // Redirect with ready and stall together: redirect wins
    redirect = 1'b1; redirect_addr = 32'h100; stall = 1'b1;
    tick();
    chk("redir_bubble", 32'(bubble), 32'd1);
    chk("redir_ins", ins, 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("redir_fetch_ins", ins, 32'hDEAD_0100);
    chk("redir_fetch_next", next_addr, 32'h104);

    // Misaligned redirect target 0x102
    redirect = 1'b1; redirect_addr = 32'h102;
    tick();
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_bubble", 32'(bubble), 32'd1);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("err_flag", 32'(misalign), 32'd1);
      chk("err_req", 32'(imem_req), 32'd0);
      chk("err_bubble", 32'(bubble), 32'd1);
    end
    redirect = 1'b1; redirect_addr = 32'h200;
    tick();
    chk("err_exit_flag", 32'(misalign), 32'd0);
    chk("err_exit_req", 32'(imem_req), 32'd1);
    chk("err_exit_addr", imem_addr, 32'h200);
    redirect = 1'b0;
    tick();
    chk("err_exit_ins", ins, 32'hDEAD_0200);
    chk("err_exit_next", next_addr, 32'h204);
`else
    chk("align_addr", imem_addr, 32'h100);
    chk("align_bubble", 32'(bubble), 32'd1);
    redirect = 1'b0;
    tick();
    chk("align_ins", ins, 32'hDEAD_0100);
    chk("align_next", next_addr, 32'h104);
`endif

    // Redirect while a word sits in the skid buffer
    stall = 1'b1;
    tick();
    chk("skid2_req", 32'(imem_req), 32'd0);
    chk("skid2_bubble", 32'(bubble), 32'd0);
    redirect = 1'b1; redirect_addr = 32'h300;
    tick();
    chk("skidredir_bubble", 32'(bubble), 32'd1);
    chk("skidredir_ins", ins, 32'h0);
    chk("skidredir_req", 32'(imem_req), 32'd1);
    chk("skidredir_addr", imem_addr, 32'h300);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("skidredir_fetch_ins", ins, 32'hDEAD_0300);
    chk("skidredir_fetch_next", next_addr, 32'h304);

    // PC wraps at the top of the address space
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("wrap_ins", ins, 32'h2152_FFFC);
    chk("wrap_next", next_addr, 32'h0);
    chk("wrap_pc", imem_addr, 32'h0);

    // Reset mid-request discards everything
    rst_n = 1'b0;
    tick();
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_bubble", 32'(bubble), 32'd1);
    chk("rst2_ins", ins, 32'h0);
    chk("rst2_next", next_addr, 32'h0);

    // Redirect during the reset-exit cycle seeds the PC
    rst_n = 1'b1; redirect = 1'b1; redirect_addr = 32'h40;
    tick();
    chk("rstredir_req", 32'(imem_req), 32'd1);
    chk("rstredir_addr", imem_addr, 32'h40);
    chk("rstredir_bubble", 32'(bubble), 32'd1);
    redirect = 1'b0;
    tick();
    chk("rstredir_ins", ins, 32'hDEAD_0040);
    chk("rstredir_next", next_addr, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
